// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters plus one registered decode stage.
// Latency 1 enabled cycle counter->outputs; CE low freezes counters and every output.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   HC_W     = 11,
  parameter int   VC_W     = 10
) (
  input  logic            PIX_CLK,
  input  logic            RST_N,
  input  logic            CE,
  output logic            HS,
  output logic            VS,
  output logic            DE,
  output logic [HC_W-1:0] HC,
  output logic [VC_W-1:0] VC,
  output logic            SOF,
  output logic            EOL
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT    = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_FIRST = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_LAST  = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT    = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_FIRST = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_LAST  = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
      $error("vga_timing_gen: every timing region must be at least 1 wide");
    end
    if ((H_TOTAL - 1) >= (1 << HC_W) || (V_TOTAL - 1) >= (1 << VC_W)) begin : g_bad_width
      $error("vga_timing_gen: counter width too small for the configured totals");
    end
  endgenerate

  logic [HC_W-1:0] h;
  logic [VC_W-1:0] v;
  logic            h_wrap;
  logic            h_active;
  logic            v_active;
  logic            h_sync;
  logic            v_sync;

  always_comb begin
    h_wrap   = (h == H_LAST);
    h_active = (h < H_ACT);
    v_active = (v < V_ACT);
    h_sync   = (h >= HS_FIRST) && (h <= HS_LAST);
    v_sync   = (v >= VS_FIRST) && (v <= VS_LAST);
  end

  always_ff @(posedge PIX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      h <= '0;
      v <= '0;
    end else if (CE) begin
      if (h_wrap) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + VC_W'(1);
      end else begin
        h <= h + HC_W'(1);
      end
    end
  end

  // Outputs decode the pre-edge counter value, so they trail h/v by one enabled cycle.
  always_ff @(posedge PIX_CLK or negedge RST_N) begin
    if (!RST_N) begin
      HC  <= '0;
      VC  <= '0;
      DE  <= 1'b0;
      SOF <= 1'b0;
      EOL <= 1'b0;
      HS  <= ~HS_POL;
      VS  <= ~VS_POL;
    end else if (CE) begin
      HC  <= h;
      VC  <= v;
      DE  <= h_active && v_active;
      SOF <= (h == '0) && (v == '0);
      EOL <= h_wrap;
      HS  <= h_sync ? HS_POL : ~HS_POL;
      // VS moves only at line start so it is edge-aligned with HS/DE at pixel 0.
      if (h == '0) begin
        VS <= v_sync ? VS_POL : ~VS_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x525 instance and a tiny 8x6 positive-polarity instance.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] hc;
    logic [15:0] vc;
    logic        sof;
    logic        eol;
  } obs_t;

  typedef struct {
    bit ce;
    int hc;
    int vc;
    bit de;
    bit hs;
    bit vs;
    bit sof;
    bit eol;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        ce_d;
  logic        ce_s;
  logic        hs_d, vs_d, de_d, sof_d, eol_d;
  logic [10:0] hc_d;
  logic [9:0]  vc_d;
  logic        hs_s, vs_s, de_s, sof_s, eol_s;
  logic [2:0]  hc_s;
  logic [2:0]  vc_s;

  int checks;
  int errors;
  int k_d;
  int k_s;

  vga_timing_gen u_dflt (
    .PIX_CLK(clk), .RST_N(rst_n), .CE(ce_d),
    .HS(hs_d), .VS(vs_d), .DE(de_d), .HC(hc_d), .VC(vc_d), .SOF(sof_d), .EOL(eol_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .HC_W(3), .VC_W(3)
  ) u_small (
    .PIX_CLK(clk), .RST_N(rst_n), .CE(ce_s),
    .HS(hs_s), .VS(vs_s), .DE(de_s), .HC(hc_s), .VC(vc_s), .SOF(sof_s), .EOL(eol_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: after k enabled edges the outputs describe raster position (k-1) mod frame.
  function automatic obs_t model(input int k, input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input bit hp, input bit vp);
    obs_t o;
    int ht, vt, p, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (k == 0) begin
      o.hs = ~hp; o.vs = ~vp; o.de = 1'b0; o.hc = '0; o.vc = '0; o.sof = 1'b0; o.eol = 1'b0;
      return o;
    end
    p = (k - 1) % (ht * vt);
    h = p % ht;
    v = p / ht;
    o.hc  = 16'(h);
    o.vc  = 16'(v);
    o.de  = (h < ha) && (v < va);
    o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    o.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    o.sof = (p == 0);
    o.eol = (h == ht - 1);
    return o;
  endfunction

  function automatic obs_t md(input int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
  endfunction

  function automatic obs_t ms(input int k);
    return model(k, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
  endfunction

  function automatic obs_t get_d();
    obs_t o;
    o.hs = hs_d; o.vs = vs_d; o.de = de_d; o.hc = 16'(hc_d); o.vc = 16'(vc_d);
    o.sof = sof_d; o.eol = eol_d;
    return o;
  endfunction

  function automatic obs_t get_s();
    obs_t o;
    o.hs = hs_s; o.vs = vs_s; o.de = de_s; o.hc = 16'(hc_s); o.vc = 16'(vc_s);
    o.sof = sof_s; o.eol = eol_s;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got hc=%0d vc=%0d de=%b hs=%b vs=%b sof=%b eol=%b, expected hc=%0d vc=%0d de=%b hs=%b vs=%b sof=%b eol=%b",
               name, got.hc, got.vc, got.de, got.hs, got.vs, got.sof, got.eol,
               exp.hc, exp.vc, exp.de, exp.hs, exp.vs, exp.sof, exp.eol);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick_d(input bit c);
    ce_d = c;
    @(posedge clk);
    #1;
    if (c && rst_n) k_d++;
  endtask

  task automatic tick_s(input bit c);
    ce_s = c;
    @(posedge clk);
    #1;
    if (c && rst_n) k_s++;
  endtask

  initial begin
    vec_t vec[12];
    obs_t exp_o;
    int de_cnt, hs_cnt, hs_first, hs_last, eol_cnt, eol_hc, idx, vs_cnt, hs_hi, last_sof, sof_n;
    bit c;
    int pat[4];

    checks = 0; errors = 0; k_d = 0; k_s = 0;
    rst_n = 1'b0; ce_d = 1'b0; ce_s = 1'b0;

    // Small config, starting right after reset: HS high at HC 5..6, strobes hold under CE=0.
    vec[0]  = '{1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[2]  = '{1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b0, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[11] = '{1'b1, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Default config: reset held 5 cycles.
    repeat (5) tick_d(1'b0);
    check_obs("dflt_reset", get_d(), md(0));
    rst_n = 1'b1;

    // One full line with CE high.
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; eol_cnt = 0; eol_hc = -1;
    for (int e = 1; e <= 800; e++) begin
      tick_d(1'b1);
      if (e == 1) begin
        check_int("first_edge_sof", int'(sof_d), 1);
        check_int("first_edge_de", int'(de_d), 1);
      end
      check_obs("dflt_line", get_d(), md(k_d));
      if (de_d) de_cnt++;
      if (!hs_d) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hc_d);
        hs_last = int'(hc_d);
      end
      if (eol_d) begin
        eol_cnt++;
        eol_hc = int'(hc_d);
      end
    end
    check_int("line_de_count", de_cnt, 640);
    check_int("line_hs_count", hs_cnt, 96);
    check_int("line_hs_first", hs_first, 656);
    check_int("line_hs_last", hs_last, 751);
    check_int("line_eol_count", eol_cnt, 1);
    check_int("line_eol_hc", eol_hc, 799);

    // CE pattern 1,0,0,1 up to (HC=300, VC=2); outputs must freeze on CE=0 cycles.
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    idx = 0;
    while (k_d < 1901 && idx < 10000) begin
      tick_d(pat[idx % 4] != 0);
      idx++;
      check_obs("dflt_ce_gated", get_d(), md(k_d));
    end
    check_int("gated_pos_hc", int'(hc_d), 300);
    check_int("gated_pos_vc", int'(vc_d), 2);

    // Asynchronous reset mid-line, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    k_d = 0;
    check_obs("mid_reset_immediate", get_d(), md(0));
    tick_d(1'b1);
    tick_d(1'b1);
    check_obs("mid_reset_held", get_d(), md(0));
    rst_n = 1'b1;
    tick_d(1'b1);
    check_obs("restart_first", get_d(), md(1));
    check_int("restart_sof", int'(sof_d), 1);
    ce_d = 1'b0;

    // Small config: table vectors.
    rst_n = 1'b0;
    tick_s(1'b0);
    k_s = 0;
    check_obs("small_reset", get_s(), ms(0));
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick_s(vec[i].ce);
      exp_o.hc = 16'(vec[i].hc); exp_o.vc = 16'(vec[i].vc);
      exp_o.de = vec[i].de; exp_o.hs = vec[i].hs; exp_o.vs = vec[i].vs;
      exp_o.sof = vec[i].sof; exp_o.eol = vec[i].eol;
      check_obs($sformatf("small_vec%0d", i), get_s(), exp_o);
    end

    // Small config: a full frame plus wrap back to (0,0).
    rst_n = 1'b0;
    tick_s(1'b0);
    k_s = 0;
    rst_n = 1'b1;
    vs_cnt = 0; hs_hi = 0;
    for (int e = 1; e <= 48; e++) begin
      tick_s(1'b1);
      if (vs_s) vs_cnt++;
      if (hs_s) hs_hi++;
      if (vs_s) check_int("small_vs_line", int'(vc_s), 4);
    end
    check_int("small_vs_cycles", vs_cnt, 8);
    check_int("small_hs_cycles", hs_hi, 12);
    check_int("small_last_hc", int'(hc_s), 7);
    check_int("small_last_vc", int'(vc_s), 5);
    check_int("small_last_eol", int'(eol_s), 1);
    tick_s(1'b1);
    check_int("small_wrap_hc", int'(hc_s), 0);
    check_int("small_wrap_vc", int'(vc_s), 0);
    check_int("small_wrap_sof", int'(sof_s), 1);

    // Small config: random CE against the reference model, with SOF spacing in enabled cycles.
    rst_n = 1'b0;
    tick_s(1'b0);
    k_s = 0;
    rst_n = 1'b1;
    last_sof = -1; sof_n = 0;
    for (int n = 0; n < 3000; n++) begin
      c = ($urandom_range(0, 3) != 0);
      tick_s(c);
      check_obs("small_random", get_s(), ms(k_s));
      if (c && sof_s) begin
        if (last_sof >= 0) check_int("small_sof_spacing", k_s - last_sof, 48);
        last_sof = k_s;
        sof_n++;
      end
    end
    check_int("small_sof_seen", int'(sof_n >= 2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
